ex_fsm_sd_ctrl: RTL and testbench
=================================

# ex_fsm_sd_ctrl

Run controller for the serial 10010 sequence detector. On a `start` pulse it captures a parallel word and feeds it LSB-first, one bit per clock, into an internal pattern-match engine. It counts the pattern hits and signals completion with a one-cycle `done` pulse. It sits between a register/host side that supplies words and the serial detection datapath, and gives the detector start, abort and status control.

## Interface
- `DW`, 16: data word width; bits serialised per run.
- `PLEN`, 5: pattern length in bits.
- `PATTERN`, 5'b10010: expected pattern; `PATTERN[0]` is the first bit expected, giving serial order 0,1,0,0,1.
- `CW`, 5: width of hit counter.
- `sclk`  in  1: clock; all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: run request; sampled only in IDLE.
- `abort`  in  1: synchronous run cancel; ignored in IDLE.
- `din`  in  DW: word to scan; captured on the accepting edge only.
- `busy`  out  1: run in progress.
- `hit`  out  1: one-cycle pulse per pattern match.
- `done`  out  1: one-cycle pulse at run end; `hit_cnt` is final in the same cycle.
- `hit_cnt`  out  CW: match count of the current or last run.

## Operation
- Reset values: `busy`=0, `hit`=0, `done`=0, `hit_cnt`=0, FSM=IDLE, shift register=0, match history cleared. Reset takes effect immediately at any point, including mid-run.
- FSM states:
  - IDLE:
    - `start`=1 → load `din` into shift register, clear bit index, clear `hit_cnt` and matcher history, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT:
    - Each cycle, present `sreg[0]` to the matcher with `vld`=1, shift right, increment bit index.
    - After bit `DW-1` is presented, go to DRAIN.
  - DRAIN: one cycle so the matcher's registered output for the last bit is counted; then go to IDLE and pulse `done`.
- Matcher behaviour:
  - Keeps a PLEN-bit history `{bit, hist[PLEN-1:1]}` and a fill count.
  - Matches when the history equals `PATTERN` and at least PLEN bits have been accepted since clear.
  - Overlapping matches all count; history never carries across runs.
- `hit_cnt` increments on each edge where `hit`=1 and saturates at 2^CW-1; no wrap.
- `start` while `busy`: ignored, no queuing, `din` not sampled.
- `abort`=1 in SHIFT or DRAIN: go to IDLE next edge; `busy` drops; no `done`; `hit_cnt` holds its partial value; a `hit` pulse already registered still completes. If `abort` and the DRAIN exit coincide, `abort` wins and no `done` is issued.

## Timing
- E0 = edge accepting `start`. `busy` is high from E0 until E(DW+1).
- Bit i is presented in the cycle after edge E(i), for i = 0..DW-1.
- If bit i completes a match, `hit` is high in the cycle after E(i+1), and `hit_cnt` updates at E(i+2).
- `done` and `busy`=0 are both registered at E(DW+1), and `hit_cnt` is final in that cycle.
- Start-to-done latency is DW+1 cycles (17 with defaults).
- Back-to-back runs: `start` may be high in the `done` cycle (FSM in IDLE). That edge begins the next run and clears `hit_cnt` one cycle later.

## Structure
- Shared package `ex_fsm_sd_pkg`:
  - State encoding (one-hot, IDLE/SHIFT/DRAIN).
  - Default `PATTERN`/`PLEN` constants.
- Sub-module `ex_sd_match`:
  - Ports: `sclk`, `rst_n`, `clr`, `vld`, `bit_in`, `match`.
  - Contents: history register and fill counter, output registered.
- Controller holds the FSM, shift register, bit index (width clog2(DW+1)) and saturating counter.

## Test plan
- Reset mid-SHIFT (`rst_n` low 2 cycles) → all outputs 0 immediately; the next `start` with `din`=16'h0012 gives `hit_cnt`=1 and a normal run.
- `din`=16'h0012 → one `hit` pulse, in the cycle after edge E5; `done` after edge E17 with `hit_cnt`=1.
- `din`=16'h9292 (overlap) → 4 `hit` pulses, for bits 4, 7, 12 and 15; `hit_cnt`=4.
- `din`=16'hFFFF, then `din`=16'h0000 → `hit_cnt`=0 for each; `done` still pulses at E17.
- `start` re-asserted at E3 with `din`=16'h0000 during a 16'h0012 run → ignored; result `hit_cnt`=1. Then back-to-back `start` in the `done` cycle → new run begins.
- `abort` at E8 during a 16'h9292 run → no `done`; `hit_cnt`=2 held; `busy` low from E9.

Source files
------------

// File: rtl/ex_fsm_sd_pkg.sv
// Shared types and defaults for the 10010 sequence-detector run controller.
package ex_fsm_sd_pkg;

  localparam int unsigned PLEN_DEF    = 5;
  localparam logic [4:0]  PATTERN_DEF = 5'b10010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_DRAIN = 3'b100
  } sd_state_t;

endpackage

// File: rtl/ex_sd_match.sv
// Serial pattern matcher: LSB-first history compare with a registered match pulse.
module ex_sd_match
  import ex_fsm_sd_pkg::*;
#(
  parameter int unsigned        PLEN    = PLEN_DEF,
  parameter logic [PLEN-1:0]    PATTERN = PATTERN_DEF
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic clr,
  input  logic vld,
  input  logic bit_in,
  output logic match
);

  localparam int unsigned FW = $clog2(PLEN);

  logic [PLEN-2:0] r_hist;
  logic [FW-1:0]   r_fill;
  logic            r_match;
  logic [PLEN-1:0] w_hist;
  logic            w_full;

  // Oldest bit leaves the window on the edge it is compared, so only PLEN-1 bits are stored.
  assign w_hist = {bit_in, r_hist};
  assign w_full = (r_fill >= FW'(PLEN - 1));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (clr) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (vld) begin
      r_hist  <= w_hist[PLEN-1:1];
      if (!w_full) r_fill <= r_fill + FW'(1);
      r_match <= w_full && (w_hist == PATTERN);
    end else begin
      r_match <= 1'b0;
    end
  end

  assign match = r_match;

endmodule

// File: rtl/ex_fsm_sd_ctrl.sv
// Run controller: serialises a captured word LSB-first into the matcher and counts hits.
module ex_fsm_sd_ctrl
  import ex_fsm_sd_pkg::*;
#(
  parameter int unsigned     DW      = 16,
  parameter int unsigned     PLEN    = PLEN_DEF,
  parameter logic [PLEN-1:0] PATTERN = PATTERN_DEF,
  parameter int unsigned     CW      = 5
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          hit,
  output logic          done,
  output logic [CW-1:0] hit_cnt
);

  localparam int unsigned IW = $clog2(DW + 1);

  sd_state_t       r_state;
  logic [DW-1:0]   r_sreg;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_cnt;
  logic            w_clr;
  logic            w_vld;
  logic            w_hit;

  assign w_clr = (r_state == S_IDLE) && start;
  // Abort also stops the bit in flight from reaching the matcher.
  assign w_vld = (r_state == S_SHIFT) && !abort;

  ex_sd_match #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_match (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .clr    (w_clr),
    .vld    (w_vld),
    .bit_in (r_sreg[0]),
    .match  (w_hit)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_hit && (r_cnt != '1)) r_cnt <= r_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sreg  <= din;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_sreg <= r_sreg >> 1;
            r_idx  <= r_idx + IW'(1);
            if (r_idx == IW'(DW - 1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= !abort;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign hit     = w_hit;
  assign done    = r_done;
  assign hit_cnt = r_cnt;

endmodule

// File: tb/tb_ex_fsm_sd_ctrl.sv
// Self-checking bench for ex_fsm_sd_ctrl against a window-scan reference model.
module tb_ex_fsm_sd_ctrl;

  localparam int         DW    = 16;
  localparam int         PLEN  = 5;
  localparam int         CMAX  = 31;
  localparam logic [4:0] PAT   = 5'b10010;

  logic          sclk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [DW-1:0] din;
  logic          busy;
  logic          hit;
  logic          done;
  logic [4:0]    hit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ex_fsm_sd_ctrl dut (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .din     (din),
    .busy    (busy),
    .hit     (hit),
    .done    (done),
    .hit_cnt (hit_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit i is set when serial bits i-PLEN+1..i of w spell the pattern.
  function automatic logic [DW-1:0] match_bits(input logic [DW-1:0] w);
    logic [DW-1:0] m;
    logic [DW-1:0] s;
    m = '0;
    for (int i = PLEN - 1; i < DW; i++) begin
      s = w >> (i - PLEN + 1);
      if (s[PLEN-1:0] == PAT) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Called at a negedge with the DUT idle; ab = edge index before the abort edge, or -1.
  task automatic run(input logic [DW-1:0] w, input int ab, input int dup);
    logic [DW-1:0] m;
    int last_acc, end_e, last, cnt;
    logic hexp;
    m        = match_bits(w);
    last_acc = (ab >= 0) ? ab : DW;
    end_e    = (ab >= 0) ? ab + 1 : DW + 1;
    last     = (ab >= 0) ? ab + 3 : DW + 1;
    din   = w;
    start = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    start = 1'b0;
    din   = DW'($urandom);
    check("busy_e0", 32'(busy), 32'd1);
    check("cnt_e0", 32'(hit_cnt), 32'd0);
    check("hit_e0", 32'(hit), 32'd0);
    for (int k = 1; k <= last; k++) begin
      abort = (k - 1 == ab);
      if (k - 1 == dup) begin
        start = 1'b1;
        din   = '0;
      end
      @(posedge sclk);
      @(negedge sclk);
      abort = 1'b0;
      start = 1'b0;
      hexp = 1'b0;
      if (k <= DW && k <= last_acc) hexp = m[k-1];
      cnt = 0;
      for (int i = 0; i < DW; i++)
        if (m[i] && (i + 1 <= last_acc) && (i + 2 <= k)) cnt++;
      if (cnt > CMAX) cnt = CMAX;
      check($sformatf("hit w=%h k=%0d", w, k), 32'(hit), 32'(hexp));
      check($sformatf("cnt w=%h k=%0d", w, k), 32'(hit_cnt), 32'(cnt));
      check($sformatf("busy w=%h k=%0d", w, k), 32'(busy), 32'(k < end_e));
      check($sformatf("done w=%h k=%0d", w, k), 32'(done), 32'((ab < 0) && (k == DW + 1)));
    end
  endtask

  initial begin
    int ab;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    din   = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(hit_cnt), 32'd0);
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);

    // Directed runs; successive calls start in the previous done cycle.
    run(16'h0012, -1, -1);
    run(16'h9292, -1, -1);
    run(16'hFFFF, -1, -1);
    run(16'h0000, -1, -1);
    run(16'h0012, -1, 3);
    run(16'h9292, -1, -1);
    run(16'h9292, 8, -1);
    run(16'h0012, DW, -1);

    // Reset in the middle of a run.
    din   = 16'h9292;
    start = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    start = 1'b0;
    repeat (8) @(negedge sclk);
    check("pre_rst_cnt", 32'(hit_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_hit", 32'(hit), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_cnt", 32'(hit_cnt), 32'd0);
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    run(16'h0012, -1, -1);

    // Randomised runs with occasional aborts and ignored re-starts.
    for (int r = 0; r < 24; r++) begin
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DW)) : -1;
      run(DW'($urandom), ab, (ab < 0) ? int'($urandom_range(0, DW - 1)) : -1);
      if ($urandom_range(0, 1) == 1) @(negedge sclk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
